// File: rtl/delay_chain_probe.sv
// delay_chain_probe: measures the round-trip delay of an external chain in clk cycles.
// A probe edge is launched into the chain, and the block counts cycles until the
// synchronized echo changes. It also reports whether the chain inverts, or gives up
// after TIMEOUT cycles.
module delay_chain_probe #(
   parameter int CNT_W      = 8,
   parameter int TIMEOUT    = 200,
   parameter int SETTLE_CYC = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             echo_in,
   output logic             probe_out,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] delay_cycles,
   output logic             inverted,
   output logic             timeout
);

   localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam logic [SW-1:0]    SET_LAST = SW'(SETTLE_CYC - 1);
   localparam logic [CNT_W-1:0] TO_VAL   = CNT_W'(TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE, S_SETTLE, S_LAUNCH, S_WAIT, S_DONE
   } state_t;

   state_t           state_q;
   logic             sync1_q, echo_s_q;
   logic             probe_q, busy_q, done_q;
   logic             echo_ref_q, inv_ref_q;
   logic [SW-1:0]    set_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] delay_q;
   logic             inverted_q, timeout_q;
   logic [CNT_W-1:0] cnt_d;

   // The count that includes the current WAIT cycle. It is the reported delay, so a
   // direct loopback reads 2, which is the synchronizer depth.
   assign cnt_d = cnt_q + 1'b1;

   // Two-flop synchronizer for the asynchronous chain return.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q  <= 1'b0;
         echo_s_q <= 1'b0;
      end else begin
         sync1_q  <= echo_in;
         echo_s_q <= sync1_q;
      end
   end

   // Measurement FSM. All outputs are registered. The probe edge is registered on
   // entry to LAUNCH, so the chain sees it during the LAUNCH cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         probe_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         echo_ref_q <= 1'b0;
         inv_ref_q  <= 1'b0;
         set_q      <= '0;
         cnt_q      <= '0;
         delay_q    <= '0;
         inverted_q <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_q <= S_SETTLE;
                  set_q   <= '0;
                  busy_q  <= 1'b1;
               end
            end
            S_SETTLE: begin
               if (set_q == SET_LAST) begin
                  echo_ref_q <= echo_s_q;
                  inv_ref_q  <= echo_s_q ^ probe_q;
                  probe_q    <= ~probe_q;
                  cnt_q      <= '0;
                  state_q    <= S_LAUNCH;
               end else begin
                  set_q <= set_q + 1'b1;
               end
            end
            S_LAUNCH: begin
               cnt_q   <= '0;
               state_q <= S_WAIT;
            end
            S_WAIT: begin
               cnt_q <= cnt_d;
               // The echo check comes first, so an echo wins over a timeout in the same cycle.
               if (echo_s_q != echo_ref_q) begin
                  delay_q    <= cnt_d;
                  inverted_q <= inv_ref_q;
                  timeout_q  <= 1'b0;
                  done_q     <= 1'b1;
                  state_q    <= S_DONE;
               end else if (cnt_d == TO_VAL) begin
                  delay_q    <= TO_VAL;
                  inverted_q <= inv_ref_q;
                  timeout_q  <= 1'b1;
                  done_q     <= 1'b1;
                  state_q    <= S_DONE;
               end
            end
            S_DONE: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign probe_out    = probe_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign delay_cycles = delay_q;
   assign inverted     = inverted_q;
   assign timeout      = timeout_q;

endmodule
